// File: rtl/cpu7_ifu_fetch_ctl.sv
// Fetch request/response tracker between the IFU fetch datapath and the instruction bus.
// Keeps an in-order FIFO of outstanding fetches tagged {kill, adef, uc}. Misaligned
// fetches are never issued to the bus; they are answered from the FIFO as ADEF exceptions.
module cpu7_ifu_fetch_ctl #(
   parameter int unsigned GRLEN     = 32,
   parameter int unsigned MAX_OUTST = 4,
   parameter logic [2:0]  UC_SEG    = 3'b101,
   parameter logic [5:0]  ADEF_CODE = 6'h08
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inst_req,
   input  logic [31:0]      inst_addr,
   input  logic             inst_cancel,
   output logic             inst_addr_ok,
   output logic             inst_valid_f,
   output logic [GRLEN-1:0] inst_rdata_f,
   output logic [1:0]       inst_count,
   output logic             inst_ex,
   output logic [5:0]       inst_exccode,
   output logic             inst_uncache,
   output logic             ibus_req,
   output logic [31:0]      ibus_addr,
   input  logic             ibus_addr_ok,
   input  logic             ibus_data_ok,
   input  logic [GRLEN-1:0] ibus_rdata
);

   localparam int unsigned PtrW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
   localparam int unsigned CntW = PtrW + 1;

   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic [MAX_OUTST-1:0] kill_q, kill_d, adef_q, adef_d, uc_q, uc_d;
   logic                 adef_pend_q, adef_pend_d;

   logic mis, full, empty, adef_acc, push, pop, pop_adef, pop_bus;
   logic head_kill, head_adef, head_uc;

   assign mis       = |inst_addr[1:0];
   assign full      = (count_q == CntW'(MAX_OUTST));
   assign empty     = (count_q == '0);
   assign head_kill = kill_q[rd_ptr_q];
   assign head_adef = adef_q[rd_ptr_q];
   assign head_uc   = uc_q[rd_ptr_q];

   // Request acceptance and response delivery; reset gates the bus-facing handshakes.
   always_comb begin
      ibus_req     = inst_req & ~mis & ~full & ~adef_pend_q & ~reset;
      // A misaligned fetch only enters an empty FIFO so its exception stays in program order.
      adef_acc     = inst_req & mis & empty & ~adef_pend_q & ~reset;
      inst_addr_ok = (ibus_req & ibus_addr_ok) | adef_acc;
      push         = inst_addr_ok;
      ibus_addr    = inst_addr;

      pop_adef     = ~empty & head_adef;
      // data_ok with nothing outstanding on the bus is a protocol violation: ignore it.
      pop_bus      = ibus_data_ok & ~empty & ~head_adef;
      pop          = pop_adef | pop_bus;

      inst_valid_f = pop & ~head_kill & ~inst_cancel;
      inst_rdata_f = (inst_valid_f & ~head_adef) ? ibus_rdata : '0;
      inst_count   = {1'b0, inst_valid_f};
      inst_ex      = inst_valid_f & head_adef;
      inst_exccode = inst_ex ? ADEF_CODE : 6'h00;
      inst_uncache = inst_valid_f & head_uc;
   end

   // Next-state for pointers, occupancy, entry tags and the ADEF blocker.
   always_comb begin
      rd_ptr_d    = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
      wr_ptr_d    = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
      count_d     = count_q;
      if (push && !pop) begin
         count_d = count_q + CntW'(1);
      end else if (!push && pop) begin
         count_d = count_q - CntW'(1);
      end

      kill_d      = kill_q;
      adef_d      = adef_q;
      uc_d        = uc_q;
      // Cancel kills everything already in flight; a request taken this cycle is the new target.
      if (inst_cancel) begin
         kill_d = '1;
      end
      if (push) begin
         kill_d[wr_ptr_q] = 1'b0;
         adef_d[wr_ptr_q] = mis;
         uc_d[wr_ptr_q]   = ~mis & (inst_addr[31:29] == UC_SEG);
      end

      adef_pend_d = adef_pend_q;
      if (adef_acc) begin
         adef_pend_d = 1'b1;
      end else if (pop_adef) begin
         adef_pend_d = 1'b0;
      end
   end

   // State registers; reset empties the FIFO immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr_q    <= '0;
         wr_ptr_q    <= '0;
         count_q     <= '0;
         kill_q      <= '0;
         adef_q      <= '0;
         uc_q        <= '0;
         adef_pend_q <= 1'b0;
      end else begin
         rd_ptr_q    <= rd_ptr_d;
         wr_ptr_q    <= wr_ptr_d;
         count_q     <= count_d;
         kill_q      <= kill_d;
         adef_q      <= adef_d;
         uc_q        <= uc_d;
         adef_pend_q <= adef_pend_d;
      end
   end

endmodule

// File: tb/tb_cpu7_ifu_fetch_ctl.sv
// Bench for cpu7_ifu_fetch_ctl: directed scenarios then randomized traffic, all checked
// against a queue-based model of outstanding fetches and a simple in-order bus model.
module tb_cpu7_ifu_fetch_ctl;

   localparam logic [31:0] KEY = 32'h1357_9bdf;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req, inst_cancel, ibus_addr_ok, ibus_data_ok;
   logic [31:0] inst_addr, ibus_rdata;
   logic        inst_addr_ok, inst_valid_f, inst_ex, inst_uncache, ibus_req;
   logic [31:0] inst_rdata_f, ibus_addr;
   logic [1:0]  inst_count;
   logic [5:0]  inst_exccode;

   int checks = 0;
   int failures = 0;
   int delivered = 0;

   typedef struct {
      bit          kill;
      bit          adef;
      bit          uc;
      logic [31:0] addr;
   } ent_t;

   ent_t        q[$];     // outstanding fetches, oldest first
   logic [31:0] busq[$];  // addresses the bus still owes data for

   cpu7_ifu_fetch_ctl dut (
      .clk          (clk),
      .reset        (reset),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_cancel  (inst_cancel),
      .inst_addr_ok (inst_addr_ok),
      .inst_valid_f (inst_valid_f),
      .inst_rdata_f (inst_rdata_f),
      .inst_count   (inst_count),
      .inst_ex      (inst_ex),
      .inst_exccode (inst_exccode),
      .inst_uncache (inst_uncache),
      .ibus_req     (ibus_req),
      .ibus_addr    (ibus_addr),
      .ibus_addr_ok (ibus_addr_ok),
      .ibus_data_ok (ibus_data_ok),
      .ibus_rdata   (ibus_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One bus cycle: drive inputs at negedge, check against the model, then advance the model.
   task automatic step(input logic req, input logic [31:0] addr, input logic cancel,
                       input logic aok, input logic dok);
      bit mis, pend, e_req, e_aok, e_valid, e_ex, e_uc, pop;
      logic [31:0] e_rdata;
      @(negedge clk);
      inst_req     = req;
      inst_addr    = addr;
      inst_cancel  = cancel;
      ibus_addr_ok = aok;
      ibus_data_ok = dok;
      ibus_rdata   = (dok && busq.size() > 0) ? (busq[0] ^ KEY) : $urandom;
      #1;
      mis  = (addr[1:0] != 2'b00);
      pend = 1'b0;
      foreach (q[i]) if (q[i].adef) pend = 1'b1;
      e_req   = req && !mis && (q.size() < 4) && !pend;
      e_aok   = (e_req && aok) || (req && mis && q.size() == 0);
      e_valid = 1'b0;
      e_ex    = 1'b0;
      e_uc    = 1'b0;
      e_rdata = '0;
      pop     = 1'b0;
      if (q.size() > 0) begin
         if (q[0].adef) begin
            pop     = 1'b1;
            e_valid = !q[0].kill && !cancel;
            e_ex    = e_valid;
         end else if (dok) begin
            pop     = 1'b1;
            e_valid = !q[0].kill && !cancel;
            e_uc    = e_valid && q[0].uc;
            e_rdata = q[0].addr ^ KEY;
         end
      end
      chk("ibus_req", 32'(ibus_req), 32'(e_req));
      chk("inst_addr_ok", 32'(inst_addr_ok), 32'(e_aok));
      chk("ibus_addr", ibus_addr, addr);
      chk("inst_valid_f", 32'(inst_valid_f), 32'(e_valid));
      chk("inst_count", 32'(inst_count), 32'(e_valid));
      chk("inst_ex", 32'(inst_ex), 32'(e_ex));
      chk("inst_exccode", 32'(inst_exccode), e_ex ? 32'h08 : 32'h0);
      chk("inst_uncache", 32'(inst_uncache), 32'(e_uc));
      if (e_valid) chk("inst_rdata_f", inst_rdata_f, e_rdata);
      if (e_valid) delivered++;
      if (pop) void'(q.pop_front());
      if (dok && busq.size() > 0) void'(busq.pop_front());
      if (cancel) foreach (q[i]) q[i].kill = 1'b1;
      if (e_aok) q.push_back('{1'b0, mis, !mis && addr[31:29] == 3'b101, addr});
      if (e_req && aok) busq.push_back(addr);
   endtask

   // Assert reset with busy inputs, check every output is quiet, then release.
   task automatic do_reset();
      @(negedge clk);
      reset        = 1'b1;
      inst_req     = 1'b1;
      inst_addr    = 32'h1c00_0000;
      inst_cancel  = 1'b0;
      ibus_addr_ok = 1'b1;
      ibus_data_ok = 1'b1;
      ibus_rdata   = 32'hffff_ffff;
      #1;
      chk("rst_ibus_req", 32'(ibus_req), 32'h0);
      chk("rst_addr_ok", 32'(inst_addr_ok), 32'h0);
      chk("rst_valid", 32'(inst_valid_f), 32'h0);
      chk("rst_rdata", inst_rdata_f, 32'h0);
      chk("rst_count", 32'(inst_count), 32'h0);
      chk("rst_ex", 32'({inst_ex, inst_exccode, inst_uncache}), 32'h0);
      chk("rst_ibus_addr", ibus_addr, 32'h1c00_0000);
      q.delete();
      busq.delete();
      @(negedge clk);
      reset        = 1'b0;
      inst_req     = 1'b0;
      ibus_data_ok = 1'b0;
      ibus_addr_ok = 1'b0;
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] base;
      base = ($urandom_range(0, 2) == 0) ? 32'ha000_0000 : 32'h1c00_0000;
      if ($urandom_range(0, 7) == 0) return base + 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      return base + 32'($urandom_range(0, 63) * 4);
   endfunction

   initial begin
      int d0;
      reset = 1'b1;
      inst_req = 0; inst_addr = 0; inst_cancel = 0;
      ibus_addr_ok = 0; ibus_data_ok = 0; ibus_rdata = 0;
      do_reset();

      // Back-to-back aligned fetches, data two cycles after each acceptance.
      d0 = delivered;
      step(1, 32'h1c00_0000, 0, 1, 0);
      step(1, 32'h1c00_0004, 0, 1, 0);
      step(1, 32'h1c00_0008, 0, 1, 1);
      step(0, 32'h1c00_000c, 0, 1, 1);
      step(0, 32'h1c00_000c, 0, 1, 1);
      chk("s1_delivered", 32'(delivered - d0), 32'd3);
      chk("s1_empty", 32'(q.size()), 32'd0);

      // Fill to capacity, then free one slot.
      for (int i = 0; i < 5; i++) step(1, 32'h1c00_0010 + 32'(i * 4), 0, 1, 0);
      chk("s2_full", 32'(q.size()), 32'd4);
      step(1, 32'h1c00_0024, 0, 1, 1);
      step(1, 32'h1c00_0024, 0, 1, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);

      // Cancel with two outstanding while the new target is accepted.
      d0 = delivered;
      step(1, 32'h1c00_0040, 0, 1, 0);
      step(1, 32'h1c00_0044, 0, 1, 0);
      step(1, 32'h1c00_0100, 1, 1, 0);
      step(0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 1);
      chk("s3_killed", 32'(delivered - d0), 32'd0);
      step(0, 0, 0, 0, 1);
      chk("s3_target", 32'(delivered - d0), 32'd1);

      // Misaligned fetch and the aligned request it blocks.
      step(1, 32'h1c00_0002, 0, 1, 0);
      step(1, 32'h1c00_0004, 0, 1, 0);
      step(1, 32'h1c00_0004, 0, 1, 0);
      step(0, 0, 0, 0, 1);

      // Uncached then cached fetch.
      step(1, 32'ha000_0000, 0, 1, 0);
      step(1, 32'h1c00_0000, 0, 1, 1);
      step(0, 0, 0, 0, 1);

      // Reset with three outstanding, then a stale response.
      for (int i = 0; i < 3; i++) step(1, 32'h1c00_0200 + 32'(i * 4), 0, 1, 0);
      do_reset();
      step(0, 0, 0, 0, 1);
      step(1, 32'h1c00_0300, 0, 1, 0);
      step(0, 0, 0, 0, 1);

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) do_reset();
         step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 9) == 0,
              $urandom_range(0, 9) < 7, busq.size() > 0 && $urandom_range(0, 1) == 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
